obstacle_spawner: RTL and testbench

OBSTACLE_SPAWNER -- requirements
Module: obstacle_spawner

---
 rtl/obstacle_spawner.sv | 111 +++++++++++
 tb/tb_obstacle_spawner.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_spawner.sv
// Obstacle spawner: random frame gap, then a 13-bit restoring mod
// of rnd by range produces a spawn position offered over valid/ack.
module obstacle_spawner #(
  parameter int MIN_GAP  = 8,
  parameter int GAP_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        frame_tick,
  input  logic [12:0] rnd,
  input  logic [10:0] range,
  input  logic        spawn_ack,
  output logic        spawn_valid,
  output logic [10:0] spawn_y,
  output logic        busy,
  output logic [7:0]  spawn_count
);

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    CALC,
    OFFER
  } state_t;

  state_t      state, state_n;
  logic [8:0]  gap_cnt;
  logic [8:0]  gap_load;
  logic [12:0] cap_rnd;
  logic [10:0] cap_range;
  logic [11:0] rem;
  logic [3:0]  bit_cnt;
  logic [12:0] sh;
  logic        ge;
  logic        tick_last;
  logic        calc_done;

  assign gap_load  = 9'(MIN_GAP) + 9'(rnd[GAP_BITS-1:0]);
  assign sh        = {rem, cap_rnd[12]};
  assign ge        = sh >= {2'b00, cap_range};
  assign tick_last = frame_tick && (gap_cnt == 9'd1);
  assign calc_done = bit_cnt == 4'd13;

  assign busy        = state != IDLE;
  assign spawn_valid = state == OFFER;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (enable) state_n = GAP;
      GAP: begin
        if (!enable)        state_n = IDLE;
        else if (tick_last) state_n = CALC;
      end
      CALC:  if (calc_done) state_n = OFFER;
      OFFER: if (spawn_ack) state_n = enable ? GAP : IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Bit cycles run at bit_cnt 0..12; the extra cycle at 13 publishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt     <= '0;
      cap_rnd     <= '0;
      cap_range   <= '0;
      rem         <= '0;
      bit_cnt     <= '0;
      spawn_y     <= '0;
      spawn_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable) gap_cnt <= gap_load;
        end
        GAP: begin
          if (enable && frame_tick) begin
            gap_cnt <= gap_cnt - 9'd1;
            if (gap_cnt == 9'd1) begin
              cap_rnd   <= rnd;
              cap_range <= range;
              rem       <= '0;
              bit_cnt   <= '0;
            end
          end
        end
        CALC: begin
          if (calc_done) begin
            spawn_y <= (cap_range == 11'd0) ? 11'd0 : rem[10:0];
          end else begin
            rem     <= ge ? 12'(sh - {2'b00, cap_range}) : sh[11:0];
            cap_rnd <= {cap_rnd[11:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        OFFER: begin
          if (spawn_ack) begin
            spawn_count <= spawn_count + 8'd1;
            gap_cnt     <= gap_load;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed testbench for obstacle_spawner.
// Each scenario task drives stimulus and checks its own results.
module tb_obstacle_spawner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        frame_tick = 1'b0;
  logic [12:0] rnd = '0;
  logic [10:0] range = '0;
  logic        spawn_ack = 1'b0;
  logic        spawn_valid;
  logic [10:0] spawn_y;
  logic        busy;
  logic [7:0]  spawn_count;

  int checks = 0;
  int failures = 0;

  obstacle_spawner #(.MIN_GAP(8), .GAP_BITS(4)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .frame_tick(frame_tick),
    .rnd(rnd),
    .range(range),
    .spawn_ack(spawn_ack),
    .spawn_valid(spawn_valid),
    .spawn_y(spawn_y),
    .busy(busy),
    .spawn_count(spawn_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    frame_tick = 1'b0;
    spawn_ack = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic arm(input logic [3:0] j);
    enable = 1'b1;
    rnd = {9'd0, j};
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  // Capture tick, then count edges until spawn_valid (bounded).
  task automatic capture(input logic [12:0] r, input logic [10:0] rg,
                         output int lat);
    rnd = r;
    range = rg;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    lat = 0;
    while (spawn_valid !== 1'b1 && lat < 40) begin
      rnd = 13'($urandom);
      range = 11'($urandom);
      step();
      lat++;
    end
  endtask

  task automatic ack();
    spawn_ack = 1'b1;
    step();
    spawn_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (spawn_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%0b exp=0", spawn_valid);
    end
    checks++;
    if (spawn_y !== 11'd0) begin
      failures++;
      $display("FAIL reset_y got=%0d exp=0", spawn_y);
    end
    checks++;
    if (spawn_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d exp=0", spawn_count);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%0b exp=0", busy);
    end
  endtask

  task automatic test_modulo();
    logic [12:0] rv [4] = '{13'd1000, 13'd50, 13'd8191, 13'd4321};
    logic [10:0] gv [4] = '{11'd300, 11'd600, 11'd2047, 11'd0};
    logic [10:0] yv [4] = '{11'd100, 11'd50, 11'd3, 11'd0};
    int lat;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      arm(4'd0);
      ticks(7);
      capture(rv[k], gv[k], lat);
      checks++;
      if (lat !== 14) begin
        failures++;
        $display("FAIL mod_latency[%0d] got=%0d exp=14", k, lat);
      end
      checks++;
      if (spawn_y !== yv[k]) begin
        failures++;
        $display("FAIL mod_y[%0d] got=%0d exp=%0d", k, spawn_y, yv[k]);
      end
      enable = 1'b0;
      ack();
      checks++;
      if (spawn_count !== 8'(k + 1)) begin
        failures++;
        $display("FAIL mod_count[%0d] got=%0d exp=%0d", k, spawn_count, k + 1);
      end
      checks++;
      if (spawn_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL mod_idle[%0d] got=%0b%0b exp=00", k, spawn_valid, busy);
      end
    end
    checks++;
    if (spawn_y !== 11'd0) begin
      failures++;
      $display("FAIL mod_y_hold got=%0d exp=0", spawn_y);
    end
  endtask

  task automatic test_gap_timing();
    int lat;
    logic saw;
    do_reset();
    arm(4'd5);
    ticks(12);
    saw = 1'b0;
    repeat (20) begin
      step();
      if (spawn_valid === 1'b1) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL gap_early got=%0b%0b exp=01", saw, busy);
    end
    capture(13'd77, 11'd10, lat);
    checks++;
    if (lat !== 14 || spawn_y !== 11'd7) begin
      failures++;
      $display("FAIL gap_13th lat=%0d y=%0d exp lat=14 y=7", lat, spawn_y);
    end
    enable = 1'b0;
    ack();
    arm(4'd0);
    ticks(3);
    enable = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL gap_disable got=%0b exp=0", busy);
    end
    ticks(10);
    checks++;
    if (busy !== 1'b0 || spawn_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_ticks got=%0b%0b exp=00", busy, spawn_valid);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic bad;
    do_reset();
    arm(4'd0);
    spawn_ack = 1'b1;
    ticks(3);
    spawn_ack = 1'b0;
    checks++;
    if (spawn_count !== 8'd0) begin
      failures++;
      $display("FAIL ack_ignored got=%0d exp=0", spawn_count);
    end
    ticks(4);
    capture(13'd1000, 11'd300, lat);
    checks++;
    if (lat !== 14) begin
      failures++;
      $display("FAIL bp_latency got=%0d exp=14", lat);
    end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rnd = 13'($urandom);
      range = 11'($urandom);
      step();
      if (spawn_valid !== 1'b1 || spawn_y !== 11'd100 ||
          spawn_count !== 8'd0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL bp_stable got=%0b exp=0", bad);
    end
    ack();
    checks++;
    if (spawn_count !== 8'd1 || spawn_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept cnt=%0d v=%0b exp cnt=1 v=0",
               spawn_count, spawn_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_reset();
    arm(4'd0);
    ticks(7);
    capture(13'd50, 11'd600, lat);
    rnd = 13'd3;
    ack();
    checks++;
    if (busy !== 1'b1 || spawn_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_regap got=%0b%0b exp=10", busy, spawn_valid);
    end
    ticks(10);
    capture(13'd8191, 11'd2047, lat);
    checks++;
    if (lat !== 14 || spawn_y !== 11'd3) begin
      failures++;
      $display("FAIL b2b_second lat=%0d y=%0d exp lat=14 y=3", lat, spawn_y);
    end
    enable = 1'b0;
    ack();
  endtask

  task automatic test_wrap_disable();
    int lat;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      arm(4'd0);
      ticks(7);
      capture(13'(i), 11'd7, lat);
      if (i == 255) begin
        checks++;
        if (spawn_count !== 8'd255) begin
          failures++;
          $display("FAIL wrap_255 got=%0d exp=255", spawn_count);
        end
      end
      enable = 1'b0;
      ack();
    end
    checks++;
    if (spawn_count !== 8'd0) begin
      failures++;
      $display("FAIL wrap_zero got=%0d exp=0", spawn_count);
    end
    arm(4'd0);
    ticks(7);
    rnd = 13'd1000;
    range = 11'd300;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    lat = 0;
    while (spawn_valid !== 1'b1 && lat < 40) begin
      if (lat == 3) enable = 1'b0;
      step();
      lat++;
    end
    checks++;
    if (lat !== 14 || spawn_y !== 11'd100) begin
      failures++;
      $display("FAIL dis_calc lat=%0d y=%0d exp lat=14 y=100", lat, spawn_y);
    end
    ack();
    checks++;
    if (spawn_count !== 8'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL dis_done cnt=%0d busy=%0b exp cnt=1 busy=0",
               spawn_count, busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic saw;
    do_reset();
    arm(4'd0);
    ticks(7);
    capture(13'd4321, 11'd1000, lat);
    enable = 1'b0;
    ack();
    checks++;
    if (spawn_y !== 11'd321 || spawn_count !== 8'd1) begin
      failures++;
      $display("FAIL rm_setup y=%0d cnt=%0d exp y=321 cnt=1",
               spawn_y, spawn_count);
    end
    arm(4'd0);
    ticks(7);
    rnd = 13'd1000;
    range = 11'd300;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (6) step();
    enable = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({spawn_valid, busy, spawn_y, spawn_count} !== 21'd0) begin
      failures++;
      $display("FAIL rm_calc v=%0b b=%0b y=%0d c=%0d exp all 0",
               spawn_valid, busy, spawn_y, spawn_count);
    end
    saw = 1'b0;
    repeat (20) begin
      step();
      if (spawn_valid === 1'b1 || busy === 1'b1) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      failures++;
      $display("FAIL rm_calc_idle got=%0b exp=0", saw);
    end
    arm(4'd0);
    ticks(7);
    capture(13'd1000, 11'd300, lat);
    enable = 1'b0;
    spawn_ack = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    spawn_ack = 1'b0;
    checks++;
    if ({spawn_valid, busy, spawn_y, spawn_count} !== 21'd0) begin
      failures++;
      $display("FAIL rm_offer v=%0b b=%0b y=%0d c=%0d exp all 0",
               spawn_valid, busy, spawn_y, spawn_count);
    end
  endtask

  initial begin
    test_reset();
    test_modulo();
    test_gap_timing();
    test_backpressure();
    test_back_to_back();
    test_wrap_disable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
